// File: rtl/nq_mem_arbiter.sv
// Arbitrates the single NanoQuarter memory port between instruction fetch and the
// data-memory stage, with data priority, a fetch starvation guard and pipeline stall.
module nq_mem_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_rd,
    input  logic              dm_wrt,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_flg,
    output logic              err_flg
);

    localparam int            BW        = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_F
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;

    // A requester whose ack is high is not pending, so its finished request is never re-granted.
    logic dm_p;
    logic if_p;
    assign dm_p = (dm_rd | dm_wrt) & ~dm_ack_q;
    assign if_p = if_req & ~if_ack_q;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (mem_ready) begin
                    err_d = 1'b1;
                end
                if (dm_p && !(if_p && (burst_cnt_q == BURST_MAX))) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_we_d    = dm_wrt;
                    if (dm_rd && dm_wrt) begin
                        err_d = 1'b1;
                    end
                    // Count only data grants that made a pending fetch wait; saturate at the limit.
                    if (!if_p) begin
                        burst_cnt_d = '0;
                    end else if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end else if (if_p) begin
                    state_d     = BUSY_F;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    burst_cnt_d = '0;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            BUSY_F: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err_flg   = err_q;
    // Held low during reset so every output reads 0 while rst is asserted.
    assign stall_flg = (dm_p | if_p) & ~rst;

endmodule
